// File: rtl/vga_pixel_fetch_if.sv
// Pixel fetch bundle: timing-generator strobes, pixel memory read port and VGA pixel output.
// master = fetch engine side, slave = the surrounding timing/memory/display logic.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 19
);
  logic              frame_start;
  logic              pix_rd;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [7:0]        rgb;
  logic              underflow;

  modport master (
    input  frame_start, pix_rd, mem_ack, mem_data,
    output mem_req, mem_addr, rgb, underflow
  );

  modport slave (
    output frame_start, pix_rd, mem_ack, mem_data,
    input  mem_req, mem_addr, rgb, underflow
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Prefetches frame pixels from memory into a small FIFO and feeds one registered RGB byte per pix_rd (1 clk).
// One read outstanding at a time, issued only while the FIFO has room; an empty FIFO on pix_rd outputs black and sets sticky underflow.
module vga_pixel_fetch #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19
) (
  input  logic            clk50MHz,
  input  logic            rst,
  vga_pixel_fetch_if.master bus
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]        rgb_q, rgb_d;
  logic              underflow_q, underflow_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];

  logic push;
  logic pop;
  logic empty;

  // frame_start overrides everything: a same-cycle ack or strobe is dropped.
  assign empty = (count_q == '0);
  assign push  = (state_q == REQ) && bus.mem_ack && !bus.frame_start;
  assign pop   = bus.pix_rd && !empty && !bus.frame_start;

  always_ff @(posedge clk50MHz) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.frame_start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (count_q < DEPTH_C) state_d = REQ;
        REQ:     if (bus.mem_ack)       state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req = (state_q == REQ);
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    rgb_d       = pop ? fifo_q[rd_ptr_q] : 8'h00;

    if (bus.frame_start) begin
      mem_addr_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_addr_d = (mem_addr_q == LAST_ADDR) ? '0 : mem_addr_q + 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (bus.pix_rd && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_data;
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rgb_q       <= 8'h00;
      underflow_q <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: validity is tracked by count and pointers.
  always_ff @(posedge clk50MHz) begin
    fifo_q <= fifo_d;
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.rgb       = rgb_q;
  assign bus.underflow = underflow_q;

endmodule
